// File: rtl/alu_operand_stage.sv
// Operand-select and decode stage in front of the combinational ALU.
// A two-entry skid buffer (output register + skid register) keeps full throughput while in_ready is registered.
module alu_operand_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic             in_is_imm,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  op1,
  output logic [XLEN-1:0]  op2,
  output logic [3:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] issued_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // the producer holds its payload stable while valid && !ready.
  logic            in_fire;
  logic            out_fire;
  logic [3:0]      dec_op;
  logic            dec_ill;
  logic [XLEN-1:0] dec_op2;

  logic            skid_valid;
  logic [XLEN-1:0] skid_op1;
  logic [XLEN-1:0] skid_op2;
  logic [3:0]      skid_alu_op;
  logic            skid_illegal;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    dec_op  = 4'b0000;
    dec_ill = 1'b0;
    case (in_funct3)
      3'b000: dec_op = (!in_is_imm && in_funct7b5) ? 4'b0001 : 4'b0000;
      3'b001: begin
        dec_op  = 4'b0101;
        dec_ill = in_funct7b5;
      end
      3'b010: dec_op = 4'b1000;
      3'b011: dec_op = 4'b1001;
      3'b100: dec_op = 4'b0100;
      3'b101: dec_op = in_funct7b5 ? 4'b0111 : 4'b0110;
      3'b110: dec_op = 4'b0011;
      default: dec_op = 4'b0010;
    endcase
    // Only ADD/SUB and SRL/SRA give bit 30 a meaning in R-type encodings.
    if (!in_is_imm && in_funct7b5 && (in_funct3 != 3'b000) && (in_funct3 != 3'b101))
      dec_ill = 1'b1;
    if (dec_ill)
      dec_op = 4'b0000;
  end

  always_comb begin
    dec_op2 = in_rs2_data;
    if (in_is_imm) begin
      if ((in_funct3 == 3'b001) || (in_funct3 == 3'b101))
        dec_op2 = {{(XLEN-5){1'b0}}, in_imm[4:0]};
      else
        dec_op2 = in_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      in_ready     <= 1'b1;
      op1          <= '0;
      op2          <= '0;
      alu_op       <= 4'b0000;
      illegal      <= 1'b0;
      skid_valid   <= 1'b0;
      skid_op1     <= '0;
      skid_op2     <= '0;
      skid_alu_op  <= 4'b0000;
      skid_illegal <= 1'b0;
      issued_count <= '0;
    end else begin
      if (out_fire)
        issued_count <= issued_count + 1'b1;

      if (out_fire && skid_valid) begin
        // in_ready is low whenever skid is full, so no new input competes here.
        op1        <= skid_op1;
        op2        <= skid_op2;
        alu_op     <= skid_alu_op;
        illegal    <= skid_illegal;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else if (in_fire && (!out_valid || out_fire)) begin
        out_valid <= 1'b1;
        op1       <= in_rs1_data;
        op2       <= dec_op2;
        alu_op    <= dec_op;
        illegal   <= dec_ill;
      end else if (in_fire) begin
        skid_valid   <= 1'b1;
        skid_op1     <= in_rs1_data;
        skid_op2     <= dec_op2;
        skid_alu_op  <= dec_op;
        skid_illegal <= dec_ill;
        in_ready     <= 1'b0;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: decode table, backpressure ordering and async reset flush.
module tb_alu_operand_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_funct3;
  logic             in_funct7b5;
  logic             in_is_imm;
  logic [XLEN-1:0]  in_rs1_data;
  logic [XLEN-1:0]  in_rs2_data;
  logic [XLEN-1:0]  in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  op1;
  logic [XLEN-1:0]  op2;
  logic [3:0]       alu_op;
  logic             illegal;
  logic [CNT_W-1:0] issued_count;

  alu_operand_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_is_imm(in_is_imm),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .op1(op1), .op2(op2), .alu_op(alu_op), .illegal(illegal),
    .issued_count(issued_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every output transfer must match the next expected op1 in order.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0)
        check("unexpected_transfer", {32'd0, op1}, 64'hDEAD);
      else
        check("order_op1", {32'd0, op1}, {32'd0, exp_q.pop_front()});
    end
  end

  typedef struct {
    logic [2:0]  f3;
    logic        f7;
    logic        is_imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] exp_op2;
    logic [3:0]  exp_alu;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[16];

  // Driver: present one transaction, step past the accepting edge, then drop valid.
  task automatic set_fields(input logic [2:0] f3, input logic f7, input logic is_imm,
                            input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    in_funct3   = f3;
    in_funct7b5 = f7;
    in_is_imm   = is_imm;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    in_imm      = imm;
  endtask

  task automatic send(input logic [2:0] f3, input logic f7, input logic is_imm,
                      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    set_fields(f3, f7, is_imm, rs1, rs2, imm);
    in_valid = 1'b1;
    exp_q.push_back(rs1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = '{3'b000, 1'b0, 1'b0, 32'd10,        32'd5,  32'd0,         32'd5,         4'b0000, 1'b0};
    vecs[1]  = '{3'b000, 1'b1, 1'b0, 32'd20,        32'd7,  32'd0,         32'd7,         4'b0001, 1'b0};
    vecs[2]  = '{3'b000, 1'b1, 1'b1, 32'd3,         32'd99, 32'd5,         32'd5,         4'b0000, 1'b0};
    vecs[3]  = '{3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'd0,  32'h405,       32'd5,         4'b0111, 1'b0};
    vecs[4]  = '{3'b101, 1'b0, 1'b1, 32'd41,        32'd0,  32'hFFFF_FFFF, 32'h1F,        4'b0110, 1'b0};
    vecs[5]  = '{3'b001, 1'b0, 1'b1, 32'd42,        32'd0,  32'h23,        32'd3,         4'b0101, 1'b0};
    vecs[6]  = '{3'b010, 1'b0, 1'b1, 32'd43,        32'd0,  32'hFFFF_FFF0, 32'hFFFF_FFF0, 4'b1000, 1'b0};
    vecs[7]  = '{3'b011, 1'b0, 1'b0, 32'd44,        32'd2,  32'd0,         32'd2,         4'b1001, 1'b0};
    vecs[8]  = '{3'b110, 1'b0, 1'b0, 32'd45,        32'd8,  32'd0,         32'd8,         4'b0011, 1'b0};
    vecs[9]  = '{3'b111, 1'b0, 1'b0, 32'd46,        32'd9,  32'd0,         32'd9,         4'b0010, 1'b0};
    vecs[10] = '{3'b100, 1'b0, 1'b0, 32'd47,        32'd11, 32'd0,         32'd11,        4'b0100, 1'b0};
    vecs[11] = '{3'b100, 1'b1, 1'b0, 32'd48,        32'd12, 32'd0,         32'd12,        4'b0000, 1'b1};
    vecs[12] = '{3'b001, 1'b1, 1'b0, 32'd49,        32'd13, 32'd0,         32'd13,        4'b0000, 1'b1};
    vecs[13] = '{3'b001, 1'b1, 1'b1, 32'd50,        32'd0,  32'h401,       32'd1,         4'b0000, 1'b1};
    vecs[14] = '{3'b110, 1'b1, 1'b1, 32'd51,        32'd0,  32'h7FF,       32'h7FF,       4'b0011, 1'b0};
    vecs[15] = '{3'b101, 1'b1, 1'b0, 32'd52,        32'd4,  32'd0,         32'd4,         4'b0111, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_fields(3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_op1",       {32'd0, op1},       64'd0);
    check("rst_op2",       {32'd0, op2},       64'd0);
    check("rst_alu_op",    {60'd0, alu_op},    64'd0);
    check("rst_illegal",   {63'd0, illegal},   64'd0);
    check("rst_issued",    {48'd0, issued_count}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Decode table at full throughput: one transaction per cycle.
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].f3, vecs[i].f7, vecs[i].is_imm, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      check($sformatf("v%0d_valid", i),   {63'd0, out_valid}, 64'd1);
      check($sformatf("v%0d_op1", i),     {32'd0, op1},       {32'd0, vecs[i].rs1});
      check($sformatf("v%0d_op2", i),     {32'd0, op2},       {32'd0, vecs[i].exp_op2});
      check($sformatf("v%0d_alu_op", i),  {60'd0, alu_op},    {60'd0, vecs[i].exp_alu});
      check($sformatf("v%0d_illegal", i), {63'd0, illegal},   {63'd0, vecs[i].exp_ill});
    end
    tick();
    check("drain_valid",  {63'd0, out_valid},     64'd0);
    check("issued_16",    {48'd0, issued_count},  64'd16);

    // Backpressure: A to output, B to skid, C stalled until space frees.
    out_ready = 1'b0;
    send(3'b000, 1'b0, 1'b0, 32'hA, 32'd1, 32'd0);
    check("bp_a_in_ready", {63'd0, in_ready}, 64'd1);
    send(3'b100, 1'b0, 1'b0, 32'hB, 32'd2, 32'd0);
    check("bp_b_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_hold_op1",   {32'd0, op1},      64'hA);
    set_fields(3'b111, 1'b0, 1'b0, 32'hC, 32'd3, 32'd0);
    in_valid = 1'b1;
    exp_q.push_back(32'hC);
    tick();
    check("bp_c_held_ready", {63'd0, in_ready}, 64'd0);
    check("bp_stall_op1",    {32'd0, op1},      64'hA);
    check("bp_stall_op2",    {32'd0, op2},      64'd1);
    check("bp_stall_alu",    {60'd0, alu_op},   64'd0);
    out_ready = 1'b1;
    tick();
    check("bp_second_b",     {32'd0, op1},      64'hB);
    check("bp_second_alu",   {60'd0, alu_op},   64'b0100);
    check("bp_ready_back",   {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_third_c",      {32'd0, op1},      64'hC);
    check("bp_third_alu",    {60'd0, alu_op},   64'b0010);
    tick();
    check("bp_done_valid",   {63'd0, out_valid},    64'd0);
    check("issued_19",       {48'd0, issued_count}, 64'd19);

    // Async reset with output and skid both full.
    out_ready = 1'b0;
    send(3'b000, 1'b0, 1'b0, 32'hD, 32'd0, 32'd0);
    send(3'b000, 1'b0, 1'b0, 32'hE, 32'd0, 32'd0);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_out_valid", {63'd0, out_valid},    64'd0);
    check("arst_in_ready",  {63'd0, in_ready},     64'd1);
    check("arst_issued",    {48'd0, issued_count}, 64'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("no_stale_%0d", i), {63'd0, out_valid}, 64'd0);
    end
    send(3'b011, 1'b0, 1'b0, 32'hF, 32'd6, 32'd0);
    check("post_rst_op1", {32'd0, op1},    64'hF);
    check("post_rst_alu", {60'd0, alu_op}, 64'b1001);
    tick();
    check("issued_1",     {48'd0, issued_count}, 64'd1);
    check("queue_empty",  {32'd0, exp_q.size()}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Pipeline stage directly upstream of the combinational ALU.
- Accepts decoded RV32I-style ALU instruction fields plus register and immediate values, and produces the 4-bit ALU opcode.
- Selects op2 (register or immediate), then registers op1, op2, alu_op and illegal toward the ALU.
- Uses a valid/ready handshake on both sides; a two-entry skid buffer provides full throughput with registered in_ready.

Parameters:
- XLEN, 32, operand width.
- CNT_W, 16, width of the issued-transaction counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream transaction valid
- in_ready  output  1  stage can accept; registered
- in_funct3  input  3  instruction funct3
- in_funct7b5  input  1  instruction bit 30 (SUB/SRA select)
- in_is_imm  input  1  1 = I-type (op2 from in_imm), 0 = R-type (op2 from in_rs2_data)
- in_rs1_data  input  XLEN  rs1 value
- in_rs2_data  input  XLEN  rs2 value
- in_imm  input  XLEN  sign-extended immediate
- out_valid  output  1  ALU operands valid
- out_ready  input  1  ALU/consumer accepts
- op1  output  XLEN  ALU operand 1
- op2  output  XLEN  ALU operand 2
- alu_op  output  4  ALU opcode
- illegal  output  1  decode illegal flag
- issued_count  output  CNT_W  count of completed output transfers

Behaviour:
- Reset (async, rst_n=0): out_valid=0, in_ready=1, op1=op2=0, alu_op=4'b0000, illegal=0, issued_count=0; both buffer entries invalidated, including any in-flight data.
- Decode is combinational on the input side and captured into the buffer on acceptance, by funct3:
  - 000: ADD 0000; R-type with f7b5=1 gives SUB 0001; I-type ignores f7b5.
  - 001: SLL 0101; f7b5=1 is illegal.
  - 010: SLT 1000.
  - 011: SLTU 1001.
  - 100: XOR 0100.
  - 101: SRL 0110 if f7b5=0, SRA 0111 if f7b5=1.
  - 110: OR 0011.
  - 111: AND 0010.
- Illegal: R-type with f7b5=1 and funct3 not in {000,101}, or funct3=001 with f7b5=1. Sets illegal=1, forces alu_op=0000, still transfers (downstream traps).
- op1 = in_rs1_data.
- op2 = in_rs2_data when in_is_imm=0.
- op2 = in_imm when in_is_imm=1 and funct3 is not 001/101.
- op2 = {27'b0, in_imm[4:0]} for I-type shifts.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = !skid_valid (registered).
- Accepted data goes to the output register if it is empty or being transferred this cycle; otherwise it goes to the skid register.
- On an output transfer with skid full, the skid entry moves to the output register and skid_valid clears; in_ready rises the next cycle.
- Simultaneous input and output transfer with skid empty: new data loads the output register; out_valid stays 1.
- Latency: 1 cycle from input transfer to out_valid.
- Sustained throughput: 1 transaction/cycle when out_ready=1.
- Strict FIFO ordering; no drops; no duplicates.
- While out_valid && !out_ready, op1/op2/alu_op/illegal are held stable.
- issued_count increments by 1 per output transfer and wraps modulo 2^CNT_W.
- Input fields are ignored when in_valid=0 or in_ready=0.

Test Plan:
- R-type, funct3=000, f7b5=0, rs1=10, rs2=5, out_ready=1 -> next cycle out_valid=1, op1=10, op2=5, alu_op=0000, illegal=0.
- R-type, funct3=000, f7b5=1 -> alu_op=0001. I-type, funct3=000, f7b5=1, imm=5 -> alu_op=0000, op2=5.
- I-type, funct3=101, f7b5=1, imm=0x405, rs1=0x80000000 -> alu_op=0111, op2=5.
- Backpressure, out_ready=0, three back-to-back inputs A, B, C:
  - A lands in the output register and B in skid; in_ready=0 the cycle after B is accepted; C is held.
  - With out_ready=1, A, B, C emerge in order on consecutive cycles.
  - issued_count=3 afterward.
- R-type, funct3=100, f7b5=1 -> illegal=1, alu_op=0000, transfer completes. funct3=001, f7b5=1 -> illegal=1.
- With output and skid both full, assert rst_n=0 mid-stream -> out_valid=0, in_ready=1, issued_count=0 immediately (async); no stale entry appears after release.
